// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the control-bundle pipeline: bundle bit positions,
// default bundle width, bubble value and scoreboard counter sizing.
package ctrl_pipe_pkg;

    localparam int CW_DEFAULT = 32;

    // Bit positions inside the decoded control bundle
    localparam int CB_REGWRITE   = 0;
    localparam int CB_MEMTOREG   = 1;
    localparam int CB_MEMWRITE   = 2;
    localparam int CB_ALUSRC     = 3;
    localparam int CB_REGDST     = 4;
    localparam int CB_MDSTART    = 5;
    localparam int CB_HILO_WE    = 6;
    localparam int CB_BRANCH     = 7;
    localparam int CB_ALUCTRL_LO = 8;
    localparam int CB_ALUCTRL_W  = 4;

    localparam logic [CW_DEFAULT-1:0] CTRL_BUBBLE = '0;

    localparam int MD_CNT_W = 6;

    function automatic logic [MD_CNT_W-1:0] md_load_value(input int cycles);
        return MD_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register holding {bds, valid, ctrl}; bubble-load takes
// priority over hold, otherwise the source word is captured.
module ctrl_stage_reg
    import ctrl_pipe_pkg::*;
#(
    parameter int W = CW_DEFAULT + 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_bubble,
    input  logic         hold,
    input  logic [W-1:0] src,
    output logic [W-1:0] q
);

    logic [W-1:0] word_q;
    logic [W-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (load_bubble) begin
            word_d = '0;
        end else if (!hold) begin
            word_d = src;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline with per-stage valid/delay-slot tags, bubble
// insertion, exception kill and an optional HI/LO busy scoreboard (CTRL_PIPE_MD_EN).
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int CW         = CW_DEFAULT,
    parameter int KILL_DEPTH = 2,
    parameter int MD_CYCLES  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CW-1:0]        ctrl_d,
    input  logic                 valid_d,
    input  logic                 bds_f,
    input  logic                 stall_d,
    input  logic [STAGES-1:0]    stall,
    input  logic [STAGES-1:0]    flush,
    input  logic                 exc_kill,
    input  logic                 md_start_e,
    input  logic                 hilo_access_d,
    output logic [STAGES*CW-1:0] ctrl_q,
    output logic [STAGES-1:0]    valid_q,
    output logic [STAGES-1:0]    bds_q,
    output logic                 md_busy,
    output logic                 md_stall_req
);

    localparam int W = CW + 2;

    logic                      bds_dq_q;
    logic                      bds_dq_d;
    logic [STAGES-1:0][W-1:0]  stage_src;
    logic [STAGES-1:0][W-1:0]  stage_word;
    logic [STAGES-1:0]         stage_bubble;

    always_comb begin
        bds_dq_d = bds_dq_q;
        if (!stall_d) begin
            bds_dq_d = bds_f;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bds_dq_q <= 1'b0;
        end else begin
            bds_dq_q <= bds_dq_d;
        end
    end

    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : g_stage
            logic kill_here;
            logic prev_stalled;

            if (i == 0) begin : g_head
                assign stage_src[i]  = {bds_dq_q, valid_d, ctrl_d};
                assign prev_stalled  = stall_d;
            end else begin : g_body
                assign stage_src[i]  = stage_word[i-1];
                assign prev_stalled  = stall[i-1];
            end

            if (i < KILL_DEPTH) begin : g_kill
                assign kill_here = exc_kill;
            end else begin : g_nokill
                assign kill_here = 1'b0;
            end

            // An upstream hold must not let this stage re-capture the held
            // instruction, so it takes a bubble unless it is itself held.
            assign stage_bubble[i] = flush[i] | kill_here | (!stall[i] & prev_stalled);

            ctrl_stage_reg #(
                .W (W)
            ) u_stage (
                .clk         (clk),
                .reset       (reset),
                .load_bubble (stage_bubble[i]),
                .hold        (stall[i]),
                .src         (stage_src[i]),
                .q           (stage_word[i])
            );

            assign ctrl_q[i*CW +: CW] = stage_word[i][CW-1:0];
            assign valid_q[i]         = stage_word[i][CW];
            assign bds_q[i]           = stage_word[i][CW+1];
        end
    endgenerate

`ifdef CTRL_PIPE_MD_EN
    localparam logic [MD_CNT_W-1:0] MD_LOAD = md_load_value(MD_CYCLES);

    logic [MD_CNT_W-1:0] md_cnt_q;
    logic [MD_CNT_W-1:0] md_cnt_d;
    logic                md_issue;

    assign md_issue = md_start_e & valid_q[0] & !stall[0];

    // Kill leaves the counter alone: the operation already left stage 0.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_issue) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy      = (md_cnt_q != '0);
    assign md_stall_req = reset & hilo_access_d & valid_d & (md_busy | md_start_e);
`else
    logic unused_md;
    assign unused_md    = ^{md_start_e, hilo_access_d};
    assign md_busy      = 1'b0;
    assign md_stall_req = 1'b0;
`endif

endmodule
